dec_scan_n: RTL and testbench

DEC_SCAN_N -- requirements
Module: dec_scan_n

---
 rtl/dec_scan_n.sv | 90 +++++++++
 tb/tb_dec_scan_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_scan_n.sv
// One-hot decoder with direct select and auto-scan modes.
// Y is indexed [0:2**N-1] so that Y[0] is the MSB and lights for select 0.
module dec_scan_n #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               En,
    input  logic               Mode,
    input  logic [N-1:0]       W,
    input  logic               Load,
    input  logic [DWELL_W-1:0] Dwell,
    output logic [0:2**N-1]    Y,
    output logic [N-1:0]       Idx,
    output logic               Wrap
);

    localparam int M = 2**N;
    localparam logic [0:M-1] ONE_MSB = {1'b1, {(M-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [N-1:0]       idx_d;
    logic [0:M-1]       y_d;
    logic               wrap_d;

    always_comb begin
        state_d  = ST_OFF;
        idx_d    = Idx;
        cnt_d    = cnt_q;
        cnt_base = cnt_q;
        wrap_d   = 1'b0;
        y_d      = '0;

        if (En) begin
            state_d = Mode ? ST_SCAN : ST_DIRECT;
        end

        unique case (state_d)
            ST_DIRECT: begin
                idx_d = W;
                cnt_d = '0;
            end
            ST_SCAN: begin
                // Leaving DIRECT, scanning always starts from a cleared count.
                cnt_base = (state_q == ST_DIRECT) ? '0 : cnt_q;
                if (Load) begin
                    idx_d = W;
                    cnt_d = '0;
                end else if (cnt_base == Dwell) begin
                    cnt_d  = '0;
                    idx_d  = Idx + 1'b1;
                    wrap_d = (Idx == '1);
                end else begin
                    cnt_d = cnt_base + 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (state_d != ST_OFF) begin
            y_d = ONE_MSB >> idx_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            Idx     <= '0;
            Y       <= '0;
            Wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            Idx     <= idx_d;
            Y       <= y_d;
            Wrap    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_dec_scan_n.sv
// Bench for dec_scan_n: N=1, 4 and 6 instances share stimulus and are
// compared every cycle against a rule-level reference model.
module tb_dec_scan_n;

    logic       Clock = 1'b0;
    logic       Resetn, En, Mode, Load;
    logic [5:0] w;
    logic [7:0] Dwell;

    logic [0:1]  y1;  logic [0:0] idx1; logic wrap1;
    logic [0:15] y4;  logic [3:0] idx4; logic wrap4;
    logic [0:63] y6;  logic [5:0] idx6; logic wrap6;

    int n_assert = 0;
    int n_fail   = 0;

    int m_idx [3];
    int m_cnt [3];
    bit m_on  [3];
    bit m_wrap[3];
    int nn    [3] = '{1, 4, 6};

    always #5 Clock = ~Clock;

    dec_scan_n #(.N(1), .DWELL_W(8)) u_n1 (
        .Clock(Clock), .Resetn(Resetn), .En(En), .Mode(Mode), .W(w[0]),
        .Load(Load), .Dwell(Dwell), .Y(y1), .Idx(idx1), .Wrap(wrap1)
    );
    dec_scan_n #(.N(4), .DWELL_W(8)) u_n4 (
        .Clock(Clock), .Resetn(Resetn), .En(En), .Mode(Mode), .W(w[3:0]),
        .Load(Load), .Dwell(Dwell), .Y(y4), .Idx(idx4), .Wrap(wrap4)
    );
    dec_scan_n #(.N(6), .DWELL_W(8)) u_n6 (
        .Clock(Clock), .Resetn(Resetn), .En(En), .Mode(Mode), .W(w),
        .Load(Load), .Dwell(Dwell), .Y(y6), .Idx(idx6), .Wrap(wrap6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int m;
            m = 1 << nn[k];
            m_wrap[k] = 1'b0;
            if (!Resetn) begin
                m_idx[k] = 0; m_cnt[k] = 0; m_on[k] = 1'b0;
            end else if (!En) begin
                m_on[k] = 1'b0;
            end else if (!Mode) begin
                m_on[k] = 1'b1; m_idx[k] = int'(w) % m; m_cnt[k] = 0;
            end else begin
                m_on[k] = 1'b1;
                if (Load) begin
                    m_idx[k] = int'(w) % m; m_cnt[k] = 0;
                end else if (m_cnt[k] == int'(Dwell)) begin
                    m_cnt[k] = 0;
                    m_idx[k] = m_idx[k] + 1;
                    if (m_idx[k] == m) begin
                        m_idx[k] = 0; m_wrap[k] = 1'b1;
                    end
                end else begin
                    m_cnt[k] = (m_cnt[k] + 1) % 256;
                end
            end
        end
    endtask

    function automatic logic [63:0] ey(input int k);
        if (!m_on[k]) return 64'd0;
        return 64'd1 << ((1 << nn[k]) - 1 - m_idx[k]);
    endfunction

    task automatic check_all();
        chk("n1_y",      64'(y1),    ey(0));
        chk("n1_idx",    64'(idx1),  64'(m_idx[0]));
        chk("n1_wrap",   64'(wrap1), 64'(m_wrap[0]));
        chk("n1_onehot", 64'($countones(y1) <= 1), 64'd1);
        chk("n4_y",      64'(y4),    ey(1));
        chk("n4_idx",    64'(idx4),  64'(m_idx[1]));
        chk("n4_wrap",   64'(wrap4), 64'(m_wrap[1]));
        chk("n4_onehot", 64'($countones(y4) <= 1), 64'd1);
        chk("n6_y",      64'(y6),    ey(2));
        chk("n6_idx",    64'(idx6),  64'(m_idx[2]));
        chk("n6_wrap",   64'(wrap6), 64'(m_wrap[2]));
        chk("n6_onehot", 64'($countones(y6) <= 1), 64'd1);
    endtask

    task automatic cycle();
        @(posedge Clock);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        // Reset with everything else asserted
        Resetn = 1'b0; En = 1'b1; Mode = 1'b1; Load = 1'b1; w = 6'd9; Dwell = 8'd0;
        cycle();
        cycle();
        chk("rst_y4",    64'(y4),    64'd0);
        chk("rst_idx4",  64'(idx4),  64'd0);
        chk("rst_wrap4", 64'(wrap4), 64'd0);

        // Direct decode sweep
        Resetn = 1'b1; Load = 1'b0; Mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w = 6'(i);
            cycle();
            chk("dir_y4",   64'(y4),   64'(16'h8000 >> i));
            chk("dir_idx4", 64'(idx4), 64'(i));
        end

        // Scan with Dwell=2 starting from Idx=0
        w = 6'd0;
        cycle();
        Mode = 1'b1; Dwell = 8'd2;
        for (int k = 1; k <= 48; k++) begin
            cycle();
            chk("scan_idx1",  64'(idx1),  64'((k / 3) % 2));
            chk("scan_idx4",  64'(idx4),  64'((k / 3) % 16));
            chk("scan_idx6",  64'(idx6),  64'((k / 3) % 64));
            chk("scan_wrap1", 64'(wrap1), 64'(k % 6 == 0));
            chk("scan_wrap4", 64'(wrap4), 64'(k == 48));
            chk("scan_wrap6", 64'(wrap6), 64'd0);
        end

        // Load on the wrap cycle wins
        Mode = 1'b0; w = 6'd15;
        cycle();
        Mode = 1'b1; Dwell = 8'd0; Load = 1'b1; w = 6'd5;
        cycle();
        chk("ldwrap_idx4",  64'(idx4),  64'd5);
        chk("ldwrap_wrap4", 64'(wrap4), 64'd0);
        Load = 1'b0;
        cycle();
        chk("ldwrap_next4", 64'(idx4),  64'd6);

        // Pause at Idx=7, counter=1, Dwell=3
        Mode = 1'b0; w = 6'd7;
        cycle();
        Mode = 1'b1; Dwell = 8'd3;
        cycle();
        En = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("off_y4",   64'(y4),   64'd0);
            chk("off_idx4", 64'(idx4), 64'd7);
        end
        En = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("resume_idx4", 64'(idx4), (i == 3) ? 64'd8 : 64'd7);
        end

        // Reset mid-scan with Load and En high
        Dwell = 8'd1;
        cycle();
        cycle();
        Resetn = 1'b0; Load = 1'b1;
        cycle();
        chk("midrst_y4",    64'(y4),    64'd0);
        chk("midrst_idx4",  64'(idx4),  64'd0);
        chk("midrst_wrap4", 64'(wrap4), 64'd0);
        Resetn = 1'b1; Load = 1'b0; Mode = 1'b0; w = 6'd3;
        cycle();
        chk("midrst_y4bit3", 64'(y4[3]), 64'd1);

        // Dwell lowered below the running count: roll over, no early step
        w = 6'd2;
        cycle();
        Mode = 1'b1; Dwell = 8'd5;
        for (int i = 0; i < 4; i++) cycle();
        Dwell = 8'd1;
        for (int k = 1; k <= 254; k++) begin
            cycle();
            chk("dwchg_idx4", 64'(idx4), (k == 254) ? 64'd3 : 64'd2);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            Resetn = ($urandom_range(0, 49) != 0);
            En     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) Mode = ~Mode;
            Load   = ($urandom_range(0, 7) == 0);
            Dwell  = 8'($urandom_range(0, 4));
            w      = 6'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
